// File: rtl/rename_regfile.sv
// rename_regfile
// Architectural register file with a circular in-order rename buffer (RRF).
// Each cycle it serves LANES dispatch lanes (two operand reads and one
// destination allocation per lane), accepts out-of-order writeback by tag,
// and retires up to LANES of the oldest entries into the ARF.
//
// Ports
//   clk, rst_n             rising-edge clock, asynchronous active-low reset
//   rd_addr0/1             per-lane source arch addresses (lane i in slice i)
//   rd_data0/1, rd_ready0/1 operand value, or the producer tag when not ready
//   alloc_en, alloc_arch   per-lane destination requests
//   alloc_tag, alloc_ok    granted tags; whole-group acceptance (combinational)
//   wb_en, wb_tag, wb_data per-lane writeback of results into RRF entries
//   commit_cnt             number of oldest entries to retire this cycle
//   flush                  discard all speculative state
//   free_count, full, empty registered occupancy status
//   alloc_err, commit_err  registered one-cycle error pulses
module rename_regfile #(
    parameter int DATA_W    = 32,
    parameter int ARCH_REGS = 32,
    parameter int RRF_DEPTH = 16,
    parameter int LANES     = 2,
    localparam int AW = $clog2(ARCH_REGS),
    localparam int TW = $clog2(RRF_DEPTH),
    localparam int CW = $clog2(LANES + 1),
    localparam int FW = $clog2(RRF_DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [LANES*AW-1:0]     rd_addr0,
    input  logic [LANES*AW-1:0]     rd_addr1,
    output logic [LANES*DATA_W-1:0] rd_data0,
    output logic [LANES*DATA_W-1:0] rd_data1,
    output logic [LANES-1:0]        rd_ready0,
    output logic [LANES-1:0]        rd_ready1,
    input  logic [LANES-1:0]        alloc_en,
    input  logic [LANES*AW-1:0]     alloc_arch,
    output logic [LANES*TW-1:0]     alloc_tag,
    output logic                    alloc_ok,
    input  logic [LANES-1:0]        wb_en,
    input  logic [LANES*TW-1:0]     wb_tag,
    input  logic [LANES*DATA_W-1:0] wb_data,
    input  logic [CW-1:0]           commit_cnt,
    input  logic                    flush,
    output logic [FW-1:0]           free_count,
    output logic                    full,
    output logic                    empty,
    output logic                    alloc_err,
    output logic                    commit_err
);

    logic [DATA_W-1:0]    arf_r      [ARCH_REGS];
    logic [ARCH_REGS-1:0] busy_r;
    logic [TW-1:0]        map_r      [ARCH_REGS];
    logic [DATA_W-1:0]    rrf_data_r [RRF_DEPTH];
    logic [RRF_DEPTH-1:0] rrf_wr_r;
    logic [AW-1:0]        rrf_dest_r [RRF_DEPTH];
    logic [TW-1:0]        head_r;
    logic [TW-1:0]        tail_r;
    logic [FW-1:0]        count_r;
    logic [FW-1:0]        free_count_r;
    logic                 full_r;
    logic                 empty_r;
    logic                 alloc_err_r;
    logic                 commit_err_r;

    logic [CW-1:0]        req_cnt_s;
    logic                 alloc_ok_s;
    logic                 alloc_err_s;
    logic                 commit_ok_s;
    logic                 commit_err_s;
    logic [TW-1:0]        wb_off_s   [LANES];
    logic [LANES-1:0]     wb_hit_s;
    logic [FW-1:0]        count_next_s;

    // Resolve one operand from start-of-cycle state: {ready, data}.
    function automatic logic [DATA_W:0] read_operand(input logic [AW-1:0] addr);
        logic [TW-1:0] tag;
        tag = map_r[addr];
        if (addr == '0) begin
            read_operand = {1'b1, {DATA_W{1'b0}}};
        end else if (!busy_r[addr]) begin
            read_operand = {1'b1, arf_r[addr]};
        end else if (rrf_wr_r[tag]) begin
            read_operand = {1'b1, rrf_data_r[tag]};
        end else begin
            read_operand = {1'b0, DATA_W'(tag)};
        end
    endfunction

    // Combinational operand reads for both source ports of every lane.
    always_comb begin
        rd_data0  = '0;
        rd_data1  = '0;
        rd_ready0 = '0;
        rd_ready1 = '0;
        for (int i = 0; i < LANES; i++) begin
            {rd_ready0[i], rd_data0[i*DATA_W +: DATA_W]} = read_operand(rd_addr0[i*AW +: AW]);
            {rd_ready1[i], rd_data1[i*DATA_W +: DATA_W]} = read_operand(rd_addr1[i*AW +: AW]);
        end
    end

    // Allocation, writeback and commit decode plus next occupancy.
    always_comb begin
        req_cnt_s = '0;
        alloc_tag = '0;
        // Requesting lanes are compacted: each lane's tag is tail plus the
        // number of requesters in front of it.
        for (int i = 0; i < LANES; i++) begin
            alloc_tag[i*TW +: TW] = tail_r + TW'(req_cnt_s);
            if (alloc_en[i]) begin
                req_cnt_s = req_cnt_s + CW'(1'b1);
            end else begin
                req_cnt_s = req_cnt_s;
            end
        end

        if (flush) begin
            alloc_ok_s  = 1'b0;
            alloc_err_s = 1'b0;
        end else if (req_cnt_s == '0) begin
            alloc_ok_s  = 1'b0;
            alloc_err_s = 1'b0;
        end else if (FW'(req_cnt_s) <= free_count_r) begin
            alloc_ok_s  = 1'b1;
            alloc_err_s = 1'b0;
        end else begin
            alloc_ok_s  = 1'b0;
            alloc_err_s = 1'b1;
        end

        commit_ok_s = 1'b1;
        if (int'(commit_cnt) > LANES) begin
            commit_ok_s = 1'b0;
        end else if (FW'(commit_cnt) > count_r) begin
            commit_ok_s = 1'b0;
        end else begin
            for (int j = 0; j < LANES; j++) begin
                if ((j < int'(commit_cnt)) && !rrf_wr_r[head_r + TW'(j)]) begin
                    commit_ok_s = 1'b0;
                end else begin
                    commit_ok_s = commit_ok_s;
                end
            end
        end
        commit_err_s = !commit_ok_s;

        // A writeback lands only on an entry that is live (between head and tail).
        for (int i = 0; i < LANES; i++) begin
            wb_off_s[i] = wb_tag[i*TW +: TW] - head_r;
            wb_hit_s[i] = wb_en[i] && !flush && (FW'(wb_off_s[i]) < count_r);
        end

        count_next_s = count_r;
        if (commit_ok_s) begin
            count_next_s = count_next_s - FW'(commit_cnt);
        end else begin
            count_next_s = count_next_s;
        end
        if (alloc_ok_s) begin
            count_next_s = count_next_s + FW'(req_cnt_s);
        end else begin
            count_next_s = count_next_s;
        end
        if (flush) begin
            count_next_s = '0;
        end else begin
            count_next_s = count_next_s;
        end
    end

    // State update: writeback, commit, allocation, then flush (later wins).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < ARCH_REGS; r++) begin
                arf_r[r] <= '0;
                map_r[r] <= '0;
            end
            for (int e = 0; e < RRF_DEPTH; e++) begin
                rrf_data_r[e] <= '0;
                rrf_dest_r[e] <= '0;
            end
            busy_r       <= '0;
            rrf_wr_r     <= '0;
            head_r       <= '0;
            tail_r       <= '0;
            count_r      <= '0;
            free_count_r <= FW'(RRF_DEPTH);
            full_r       <= 1'b0;
            empty_r      <= 1'b1;
            alloc_err_r  <= 1'b0;
            commit_err_r <= 1'b0;
        end else begin
            alloc_err_r  <= alloc_err_s;
            commit_err_r <= commit_err_s;
            count_r      <= count_next_s;
            free_count_r <= FW'(RRF_DEPTH) - count_next_s;
            full_r       <= (count_next_s == FW'(RRF_DEPTH));
            empty_r      <= (count_next_s == '0);

            for (int i = 0; i < LANES; i++) begin
                if (wb_hit_s[i]) begin
                    rrf_data_r[wb_tag[i*TW +: TW]] <= wb_data[i*DATA_W +: DATA_W];
                    rrf_wr_r[wb_tag[i*TW +: TW]]   <= 1'b1;
                end
            end

            // Entries retire oldest first, so the youngest of several writers
            // to one dest is the last assignment and lands in the ARF.
            if (commit_ok_s) begin
                for (int j = 0; j < LANES; j++) begin
                    if (j < int'(commit_cnt)) begin
                        if (rrf_dest_r[head_r + TW'(j)] != '0) begin
                            arf_r[rrf_dest_r[head_r + TW'(j)]] <= rrf_data_r[head_r + TW'(j)];
                        end
                        // A same-cycle allocation to this reg re-sets busy below.
                        if (map_r[rrf_dest_r[head_r + TW'(j)]] == head_r + TW'(j)) begin
                            busy_r[rrf_dest_r[head_r + TW'(j)]] <= 1'b0;
                        end
                    end
                end
                head_r <= head_r + TW'(commit_cnt);
            end

            // Lanes are visited in order so the highest lane owns the map.
            if (alloc_ok_s) begin
                for (int i = 0; i < LANES; i++) begin
                    if (alloc_en[i]) begin
                        rrf_wr_r[alloc_tag[i*TW +: TW]]   <= 1'b0;
                        rrf_dest_r[alloc_tag[i*TW +: TW]] <= alloc_arch[i*AW +: AW];
                        if (alloc_arch[i*AW +: AW] != '0) begin
                            busy_r[alloc_arch[i*AW +: AW]] <= 1'b1;
                            map_r[alloc_arch[i*AW +: AW]]  <= alloc_tag[i*TW +: TW];
                        end
                    end
                end
                tail_r <= tail_r + TW'(req_cnt_s);
            end

            if (flush) begin
                busy_r   <= '0;
                rrf_wr_r <= '0;
                head_r   <= tail_r;
            end
        end
    end

    assign alloc_ok   = alloc_ok_s;
    assign free_count = free_count_r;
    assign full       = full_r;
    assign empty      = empty_r;
    assign alloc_err  = alloc_err_r;
    assign commit_err = commit_err_r;

endmodule

// File: tb/tb_rename_regfile.sv
// Self-checking bench for rename_regfile: a directed walk through the main
// scenarios followed by randomized traffic, all compared every cycle against
// a queue-based reference model of the rename buffer.
module tb_rename_regfile;

    localparam int DW    = 32;
    localparam int NREG  = 32;
    localparam int D     = 16;
    localparam int LANES = 2;
    localparam int AW    = 5;
    localparam int TW    = 4;
    localparam int CW    = 2;
    localparam int FW    = 5;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [LANES*AW-1:0]  rd_addr0, rd_addr1;
    logic [LANES*DW-1:0]  rd_data0, rd_data1;
    logic [LANES-1:0]     rd_ready0, rd_ready1;
    logic [LANES-1:0]     alloc_en;
    logic [LANES*AW-1:0]  alloc_arch;
    logic [LANES*TW-1:0]  alloc_tag;
    logic                 alloc_ok;
    logic [LANES-1:0]     wb_en;
    logic [LANES*TW-1:0]  wb_tag;
    logic [LANES*DW-1:0]  wb_data;
    logic [CW-1:0]        commit_cnt;
    logic                 flush;
    logic [FW-1:0]        free_count;
    logic                 full, empty, alloc_err, commit_err;

    always #5 clk = ~clk;

    rename_regfile #(.DATA_W(DW), .ARCH_REGS(NREG), .RRF_DEPTH(D), .LANES(LANES)) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
        .rd_data0(rd_data0), .rd_data1(rd_data1),
        .rd_ready0(rd_ready0), .rd_ready1(rd_ready1),
        .alloc_en(alloc_en), .alloc_arch(alloc_arch),
        .alloc_tag(alloc_tag), .alloc_ok(alloc_ok),
        .wb_en(wb_en), .wb_tag(wb_tag), .wb_data(wb_data),
        .commit_cnt(commit_cnt), .flush(flush),
        .free_count(free_count), .full(full), .empty(empty),
        .alloc_err(alloc_err), .commit_err(commit_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int          tag;
        int          dest;
        bit          wr;
        logic [31:0] data;
    } ent_t;

    ent_t        mq[$];            // live RRF entries, oldest first
    logic [31:0] m_arf  [NREG];
    bit          m_busy [NREG];
    int          m_map  [NREG];
    int          m_tail;
    int          m_free;           // registered free_count
    bit          m_aerr, m_cerr;   // registered error pulses

    task automatic model_reset();
        for (int r = 0; r < NREG; r++) begin
            m_arf[r] = '0; m_busy[r] = 1'b0; m_map[r] = 0;
        end
        mq.delete();
        m_tail = 0; m_free = D; m_aerr = 1'b0; m_cerr = 1'b0;
    endtask

    function automatic void exp_read(input int a, output bit rdy, output logic [31:0] d);
        rdy = 1'b1;
        d   = '0;
        if (a == 0) begin
            d = '0;
        end else if (!m_busy[a]) begin
            d = m_arf[a];
        end else begin
            rdy = 1'b0;
            d   = m_map[a];
            foreach (mq[k]) begin
                if (mq[k].tag == m_map[a] && mq[k].wr) begin
                    rdy = 1'b1;
                    d   = mq[k].data;
                end
            end
        end
    endfunction

    function automatic int num_req();
        int n = 0;
        for (int i = 0; i < LANES; i++) if (alloc_en[i]) n++;
        return n;
    endfunction

    function automatic bit alloc_targets(input int dest);
        for (int i = 0; i < LANES; i++)
            if (alloc_en[i] && int'(alloc_arch[i*AW +: AW]) == dest) return 1'b1;
        return 1'b0;
    endfunction

    task automatic compare_model();
        bit          rdy;
        logic [31:0] d;
        int          req, k;
        bit          ok;
        for (int i = 0; i < LANES; i++) begin
            exp_read(int'(rd_addr0[i*AW +: AW]), rdy, d);
            check_eq($sformatf("rd_ready0[%0d]", i), 64'(rd_ready0[i]), 64'(rdy));
            check_eq($sformatf("rd_data0[%0d]", i), 64'(rd_data0[i*DW +: DW]), 64'(d));
            exp_read(int'(rd_addr1[i*AW +: AW]), rdy, d);
            check_eq($sformatf("rd_ready1[%0d]", i), 64'(rd_ready1[i]), 64'(rdy));
            check_eq($sformatf("rd_data1[%0d]", i), 64'(rd_data1[i*DW +: DW]), 64'(d));
        end
        req = num_req();
        ok  = !flush && req > 0 && req <= m_free;
        check_eq("alloc_ok", 64'(alloc_ok), 64'(ok));
        if (ok) begin
            k = 0;
            for (int i = 0; i < LANES; i++) begin
                if (alloc_en[i]) begin
                    check_eq($sformatf("alloc_tag[%0d]", i), 64'(alloc_tag[i*TW +: TW]), 64'((m_tail + k) % D));
                    k++;
                end
            end
        end
        check_eq("free_count", 64'(free_count), 64'(m_free));
        check_eq("full", 64'(full), 64'(m_free == 0));
        check_eq("empty", 64'(empty), 64'(m_free == D));
        check_eq("alloc_err", 64'(alloc_err), 64'(m_aerr));
        check_eq("commit_err", 64'(commit_err), 64'(m_cerr));
    endtask

    task automatic model_step();
        int   req, cnt, k, t, a;
        bit   ok, cok;
        ent_t e;
        req = num_req();
        ok  = !flush && req > 0 && req <= m_free;
        cnt = int'(commit_cnt);
        cok = (cnt <= mq.size());
        for (int j = 0; j < cnt; j++) if (cok && !mq[j].wr) cok = 1'b0;
        if (cok) begin
            for (int j = 0; j < cnt; j++) begin
                e = mq.pop_front();
                if (e.dest != 0) m_arf[e.dest] = e.data;
                if (m_busy[e.dest] && m_map[e.dest] == e.tag && !(ok && alloc_targets(e.dest)))
                    m_busy[e.dest] = 1'b0;
            end
        end
        if (!flush) begin
            for (int i = 0; i < LANES; i++) begin
                if (wb_en[i]) begin
                    for (int q = 0; q < mq.size(); q++) begin
                        if (mq[q].tag == int'(wb_tag[i*TW +: TW])) begin
                            e = mq[q]; e.wr = 1'b1; e.data = wb_data[i*DW +: DW]; mq[q] = e;
                        end
                    end
                end
            end
        end
        if (ok) begin
            k = 0;
            for (int i = 0; i < LANES; i++) begin
                if (alloc_en[i]) begin
                    t = (m_tail + k) % D;
                    a = int'(alloc_arch[i*AW +: AW]);
                    mq.push_back('{tag: t, dest: a, wr: 1'b0, data: 32'h0});
                    if (a != 0) begin
                        m_busy[a] = 1'b1; m_map[a] = t;
                    end
                    k++;
                end
            end
            m_tail = (m_tail + req) % D;
        end
        if (flush) begin
            for (int r = 0; r < NREG; r++) m_busy[r] = 1'b0;
            mq.delete();
        end
        m_aerr = !flush && req > 0 && !ok;
        m_cerr = !cok;
        m_free = D - mq.size();
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic set_idle();
        rd_addr0 = '0; rd_addr1 = '0; alloc_en = '0; alloc_arch = '0;
        wb_en = '0; wb_tag = '0; wb_data = '0; commit_cnt = '0; flush = 1'b0;
    endtask

    // Called at a falling edge with inputs driven; returns at the next one.
    task automatic run_cycle();
        #1;
        compare_model();
        model_step();
        @(posedge clk);
        @(negedge clk);
        set_idle();
    endtask

    task automatic randomize_inputs();
        set_idle();
        for (int i = 0; i < LANES; i++) begin
            rd_addr0[i*AW +: AW]   = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 7));
            rd_addr1[i*AW +: AW]   = AW'($urandom_range(0, 7));
            alloc_arch[i*AW +: AW] = AW'($urandom_range(0, 7));
            wb_en[i]               = 1'($urandom_range(0, 1));
            if (mq.size() > 0 && $urandom_range(0, 9) < 8)
                wb_tag[i*TW +: TW] = TW'(mq[$urandom_range(0, mq.size() - 1)].tag);
            else
                wb_tag[i*TW +: TW] = TW'($urandom_range(0, D - 1));
            wb_data[i*DW +: DW] = $urandom;
        end
        alloc_en   = LANES'($urandom_range(0, 3));
        commit_cnt = CW'($urandom_range(0, 2));
        flush      = ($urandom_range(0, 39) == 0);
    endtask

    task automatic mid_reset();
        rst_n = 1'b0;
        set_idle();
        rd_addr0[0 +: AW] = 5'd3;
        #1;
        model_reset();
        check_eq("midreset_free_count", 64'(free_count), 64'd16);
        check_eq("midreset_empty", 64'(empty), 64'd1);
        compare_model();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        set_idle();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        rst_n = 1'b0;
        set_idle();
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset state: r5 reads as 0/ready, buffer empty.
        rd_addr0[0 +: AW] = 5'd5;
        #1;
        check_eq("reset_r5_data", 64'(rd_data0[0 +: DW]), 64'd0);
        check_eq("reset_r5_ready", 64'(rd_ready0[0]), 64'd1);
        check_eq("reset_free_count", 64'(free_count), 64'd16);
        check_eq("reset_empty", 64'(empty), 64'd1);
        run_cycle();

        // Two lanes rename r3; lane 1 must own the mapping.
        alloc_en = 2'b11; alloc_arch = {5'd3, 5'd3};
        #1;
        check_eq("dup_tag0", 64'(alloc_tag[0 +: TW]), 64'd0);
        check_eq("dup_tag1", 64'(alloc_tag[TW +: TW]), 64'd1);
        check_eq("dup_ok", 64'(alloc_ok), 64'd1);
        run_cycle();
        rd_addr0[0 +: AW] = 5'd3;
        #1;
        check_eq("r3_pending_ready", 64'(rd_ready0[0]), 64'd0);
        check_eq("r3_pending_tag", 64'(rd_data0[0 +: DW]), 64'd1);
        run_cycle();
        wb_en = 2'b01; wb_tag[0 +: TW] = 4'd1; wb_data[0 +: DW] = 32'hA5A5A5A5;
        run_cycle();
        rd_addr0[0 +: AW] = 5'd3;
        #1;
        check_eq("r3_wb_ready", 64'(rd_ready0[0]), 64'd1);
        check_eq("r3_wb_data", 64'(rd_data0[0 +: DW]), 64'hA5A5A5A5);
        run_cycle();

        // Fill the buffer, then overflow request.
        for (int c = 0; c < 7; c++) begin
            alloc_en = 2'b11;
            alloc_arch = {5'(11 + 2 * c), 5'(10 + 2 * c)};
            run_cycle();
        end
        alloc_en = 2'b11; alloc_arch = {5'd27, 5'd26};
        #1;
        check_eq("overflow_ok", 64'(alloc_ok), 64'd0);
        check_eq("overflow_full", 64'(full), 64'd1);
        run_cycle();
        wb_en = 2'b01; wb_tag[0 +: TW] = 4'd0; wb_data[0 +: DW] = 32'h11111111;
        #1;
        check_eq("overflow_alloc_err", 64'(alloc_err), 64'd1);
        run_cycle();
        commit_cnt = 2'd2;
        run_cycle();
        alloc_en = 2'b11; alloc_arch = {5'd25, 5'd24};
        #1;
        check_eq("freed_free_count", 64'(free_count), 64'd2);
        check_eq("wrap_tag0", 64'(alloc_tag[0 +: TW]), 64'd0);
        check_eq("wrap_tag1", 64'(alloc_tag[TW +: TW]), 64'd1);
        check_eq("wrap_ok", 64'(alloc_ok), 64'd1);
        run_cycle();

        // Commit of a partially written group must be refused.
        wb_en = 2'b01; wb_tag[0 +: TW] = 4'd2; wb_data[0 +: DW] = 32'h22222222;
        run_cycle();
        commit_cnt = 2'd2;
        run_cycle();
        commit_cnt = 2'd1;
        #1;
        check_eq("partial_commit_err", 64'(commit_err), 64'd1);
        run_cycle();
        alloc_en = 2'b01; alloc_arch[0 +: AW] = 5'd9;
        #1;
        check_eq("head_kept_commit_err", 64'(commit_err), 64'd0);
        check_eq("one_free", 64'(free_count), 64'd1);
        check_eq("r9_tag", 64'(alloc_tag[0 +: TW]), 64'd2);
        run_cycle();

        // Flush with a pending allocation request.
        flush = 1'b1; alloc_en = 2'b01; alloc_arch[0 +: AW] = 5'd9;
        #1;
        check_eq("flush_alloc_ok", 64'(alloc_ok), 64'd0);
        run_cycle();
        rd_addr0[0 +: AW] = 5'd9; rd_addr1[0 +: AW] = 5'd3;
        alloc_en = 2'b01; alloc_arch[0 +: AW] = 5'd7;
        #1;
        check_eq("flush_no_alloc_err", 64'(alloc_err), 64'd0);
        check_eq("flush_free_count", 64'(free_count), 64'd16);
        check_eq("r9_after_flush_ready", 64'(rd_ready0[0]), 64'd1);
        check_eq("r9_after_flush_data", 64'(rd_data0[0 +: DW]), 64'd0);
        check_eq("r3_youngest_commit", 64'(rd_data1[0 +: DW]), 64'hA5A5A5A5);
        check_eq("r7_tag", 64'(alloc_tag[0 +: TW]), 64'd3);
        run_cycle();

        // Commit r7 while the same cycle re-renames r7.
        wb_en = 2'b01; wb_tag[0 +: TW] = 4'd3; wb_data[0 +: DW] = 32'h5A5A5A5A;
        run_cycle();
        commit_cnt = 2'd1; alloc_en = 2'b01; alloc_arch[0 +: AW] = 5'd7;
        run_cycle();
        rd_addr0[0 +: AW] = 5'd7; flush = 1'b1;
        #1;
        check_eq("r7_still_busy", 64'(rd_ready0[0]), 64'd0);
        check_eq("r7_new_tag", 64'(rd_data0[0 +: DW]), 64'd4);
        run_cycle();
        rd_addr0[0 +: AW] = 5'd7;
        #1;
        check_eq("r7_arf_value", 64'(rd_data0[0 +: DW]), 64'h5A5A5A5A);
        run_cycle();

        // Randomized traffic with one asynchronous reset in the middle.
        for (int c = 0; c < 2000; c++) begin
            if (c == 900) mid_reset();
            randomize_inputs();
            run_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
